// File: rtl/ddr3_test_reset_seq.sv
// Reset/start sequencer for a DDR3 controller test harness: debounced push
// button, global/soft reset pulses, calibration wait with tick-based timeouts.
module ddr3_test_reset_seq #(
  parameter int TICK_DIV      = 4000000,
  parameter int DB_LEN        = 3,
  parameter int GRST_CYC      = 64,
  parameter int SRST_CYC      = 32,
  parameter int TIMEOUT_TICKS = 64
) (
  input  logic       iCLK,
  input  logic       iRST_n,
  input  logic       iBUTTON,
  input  logic       iPLL_LOCK,
  input  logic       iLOCAL_INIT_DONE,
  input  logic       iCAL_SUCCESS,
  input  logic       iCAL_FAIL,
  output logic       oGLOBAL_RESET_n,
  output logic       oSOFT_RESET_n,
  output logic       oSTART_n,
  output logic [2:0] oSTATE,
  output logic       oTIMEOUT,
  output logic       oBTN_DB
);

  typedef enum logic [2:0] {
    S_GRST      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_SRST      = 3'd2,
    S_WAIT_CAL  = 3'd3,
    S_START     = 3'd4,
    S_RUN       = 3'd5,
    S_FAULT     = 3'd6
  } state_t;

  localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CYC_MAX = (GRST_CYC > SRST_CYC) ? GRST_CYC : SRST_CYC;
  localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
  localparam int TO_W    = (TIMEOUT_TICKS > 0) ? $clog2(TIMEOUT_TICKS + 1) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [CYC_W-1:0]  GRST_LAST = CYC_W'(GRST_CYC - 1);
  localparam logic [CYC_W-1:0]  SRST_LAST = CYC_W'(SRST_CYC - 1);
  localparam logic [CYC_W-1:0]  CYC_SAT   = {CYC_W{1'b1}};
  localparam logic [TO_W-1:0]   TO_LIMIT  = TO_W'(TIMEOUT_TICKS);

  logic              btn_s1, btn_s2;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic [DB_LEN-1:0] db_sr;
  logic              btn_db, btn_db_q;
  logic              db_flip, press;

  state_t            state, state_nxt;
  logic [CYC_W-1:0]  cyc_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              timeout, to_fault, restart;
  logic              glob_nxt, soft_nxt, start_nxt, tout_nxt;

  // Button front end: two-flop synchroniser, sample tick, debounce shifter.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      btn_s1   <= 1'b1;
      btn_s2   <= 1'b1;
      tick_cnt <= '0;
      db_sr    <= '1;
      btn_db   <= 1'b1;
      btn_db_q <= 1'b1;
    end else begin
      btn_s1   <= iBUTTON;
      btn_s2   <= btn_s1;
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      btn_db_q <= btn_db;
      if (tick)    db_sr  <= (db_sr << 1) | DB_LEN'(btn_s2);
      if (db_flip) btn_db <= ~btn_db;
    end
  end

  assign tick    = (tick_cnt == TICK_LAST);
  assign db_flip = btn_db ? (db_sr == '0) : (&db_sr);
  assign press   = btn_db_q & ~btn_db;
  assign timeout = (to_cnt == TO_LIMIT);
  assign restart = press || (state_nxt != state);

  // State register, per-state counters and registered outputs.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state           <= S_GRST;
      cyc_cnt         <= '0;
      to_cnt          <= '0;
      oGLOBAL_RESET_n <= 1'b0;
      oSOFT_RESET_n   <= 1'b0;
      oSTART_n        <= 1'b1;
      oTIMEOUT        <= 1'b0;
    end else begin
      state           <= state_nxt;
      cyc_cnt         <= restart ? '0 : (cyc_cnt == CYC_SAT) ? cyc_cnt : cyc_cnt + 1'b1;
      to_cnt          <= restart ? '0 : (tick && !timeout) ? to_cnt + 1'b1 : to_cnt;
      oGLOBAL_RESET_n <= glob_nxt;
      oSOFT_RESET_n   <= soft_nxt;
      oSTART_n        <= start_nxt;
      oTIMEOUT        <= tout_nxt;
    end
  end

  // Next state; a press overrides every other transition.
  // NOTE: every combinational output gets a default first so no path
  // through the case leaves it unassigned (which would infer a latch).
  always_comb begin
    state_nxt = state;
    to_fault  = 1'b0;
    if (press) begin
      state_nxt = S_GRST;
    end else begin
      case (state)
        S_GRST:      if (cyc_cnt == GRST_LAST) state_nxt = S_WAIT_LOCK;
        S_WAIT_LOCK: begin
          if (iPLL_LOCK) state_nxt = S_SRST;
          else if (timeout) begin
            state_nxt = S_FAULT;
            to_fault  = 1'b1;
          end
        end
        S_SRST:      if (cyc_cnt == SRST_LAST) state_nxt = S_WAIT_CAL;
        S_WAIT_CAL: begin
          if (iCAL_FAIL) state_nxt = S_FAULT;
          else if (iLOCAL_INIT_DONE && iCAL_SUCCESS) state_nxt = S_START;
          else if (timeout) begin
            state_nxt = S_FAULT;
            to_fault  = 1'b1;
          end
        end
        S_START:     state_nxt = S_RUN;
        S_RUN:       if (!iPLL_LOCK) state_nxt = S_FAULT;
        S_FAULT:     state_nxt = S_FAULT;
        default:     state_nxt = S_GRST;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with oSTATE.
  always_comb begin
    glob_nxt  = 1'b1;
    soft_nxt  = 1'b1;
    start_nxt = 1'b1;
    tout_nxt  = oTIMEOUT;
    case (state_nxt)
      S_GRST: begin
        glob_nxt = 1'b0;
        soft_nxt = 1'b0;
        tout_nxt = 1'b0;
      end
      S_SRST:  soft_nxt  = 1'b0;
      S_START: start_nxt = 1'b0;
      S_FAULT: if (to_fault) tout_nxt = 1'b1;
      default: ;
    endcase
  end

  assign oSTATE  = state;
  assign oBTN_DB = btn_db;

endmodule

// File: tb/tb_ddr3_test_reset_seq.sv
// Bench for ddr3_test_reset_seq: directed scenarios plus a randomized run,
// all outputs compared every cycle against a behavioural model.
module tb_ddr3_test_reset_seq;

  localparam int TICK_DIV      = 4;
  localparam int DB_LEN        = 3;
  localparam int GRST_CYC      = 8;
  localparam int SRST_CYC      = 4;
  localparam int TIMEOUT_TICKS = 16;

  localparam int ST_GRST = 0, ST_WAIT_LOCK = 1, ST_SRST = 2, ST_WAIT_CAL = 3;
  localparam int ST_START = 4, ST_RUN = 5, ST_FAULT = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       button = 1'b1;
  logic       lock = 1'b0, init_done = 1'b0, cal_ok = 1'b0, cal_fail = 1'b0;
  logic       glob_n, soft_n, start_n, tout, btn_db;
  logic [2:0] state;

  always #5 clk = ~clk;

  ddr3_test_reset_seq #(
    .TICK_DIV(TICK_DIV), .DB_LEN(DB_LEN), .GRST_CYC(GRST_CYC),
    .SRST_CYC(SRST_CYC), .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) dut (
    .iCLK(clk), .iRST_n(rst_n), .iBUTTON(button), .iPLL_LOCK(lock),
    .iLOCAL_INIT_DONE(init_done), .iCAL_SUCCESS(cal_ok), .iCAL_FAIL(cal_fail),
    .oGLOBAL_RESET_n(glob_n), .oSOFT_RESET_n(soft_n), .oSTART_n(start_n),
    .oSTATE(state), .oTIMEOUT(tout), .oBTN_DB(btn_db)
  );

  int checks = 0, errors = 0, cyc = 0;
  int s_glob_low, s_soft_low, s_start, s_wait_lock, s_btn_low;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Behavioural model: raw-button delay line, tick from edge count, last
  // DB_LEN tick samples, and a state with its age and ticks since entry.
  int   m_edges, m_state, m_age, m_ticks;
  logic m_pipe[$];
  logic m_hist[$];
  logic m_btn, m_fell, m_tout;

  task automatic model_reset();
    m_edges = 0;
    m_pipe  = {1'b1, 1'b1};
    m_hist  = {};
    repeat (DB_LEN) m_hist.push_back(1'b1);
    m_btn   = 1'b1;
    m_fell  = 1'b0;
    m_state = ST_GRST;
    m_age   = 0;
    m_ticks = 0;
    m_tout  = 1'b0;
  endtask

  task automatic model_step();
    bit   tick_now, all_opp, press_now;
    logic synced;
    int   nxt;
    tick_now = (m_edges % TICK_DIV) == TICK_DIV - 1;
    m_edges++;
    synced = m_pipe.pop_front();
    m_pipe.push_back(button);
    press_now = m_fell;
    all_opp = 1'b1;
    foreach (m_hist[i]) if (m_hist[i] == m_btn) all_opp = 1'b0;
    m_fell = all_opp && m_btn;
    if (all_opp) m_btn = !m_btn;
    if (tick_now) begin
      void'(m_hist.pop_front());
      m_hist.push_back(synced);
    end
    nxt = m_state;
    if (press_now) nxt = ST_GRST;
    else case (m_state)
      ST_GRST:      if (m_age == GRST_CYC - 1) nxt = ST_WAIT_LOCK;
      ST_WAIT_LOCK: if (lock) nxt = ST_SRST;
                    else if (m_ticks >= TIMEOUT_TICKS) begin nxt = ST_FAULT; m_tout = 1'b1; end
      ST_SRST:      if (m_age == SRST_CYC - 1) nxt = ST_WAIT_CAL;
      ST_WAIT_CAL:  if (cal_fail) nxt = ST_FAULT;
                    else if (init_done && cal_ok) nxt = ST_START;
                    else if (m_ticks >= TIMEOUT_TICKS) begin nxt = ST_FAULT; m_tout = 1'b1; end
      ST_START:     nxt = ST_RUN;
      ST_RUN:       if (!lock) nxt = ST_FAULT;
      default:      nxt = m_state;
    endcase
    if (nxt == ST_GRST) m_tout = 1'b0;
    if (press_now || nxt != m_state) begin
      m_age = 0;
      m_ticks = 0;
    end else begin
      m_age++;
      if (tick_now) m_ticks++;
    end
    m_state = nxt;
  endtask

  task automatic clear_stats();
    s_glob_low = 0; s_soft_low = 0; s_start = 0; s_wait_lock = 0; s_btn_low = 0;
  endtask

  // The single per-cycle comparison of every DUT output against the model.
  task automatic compare();
    logic [7:0] got, exp;
    got = {state, glob_n, soft_n, start_n, tout, btn_db};
    exp = {3'(m_state), m_state != ST_GRST, !(m_state == ST_GRST || m_state == ST_SRST),
           m_state != ST_START, m_tout, m_btn};
    check($sformatf("cyc%0d outputs{st,grst_n,srst_n,start_n,tmo,btn}", cyc), got, exp);
    if (glob_n === 1'b0)  s_glob_low++;
    if (soft_n === 1'b0)  s_soft_low++;
    if (start_n === 1'b0) s_start++;
    if (state === 3'd1)   s_wait_lock++;
    if (btn_db === 1'b0)  s_btn_low++;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    cyc++;
    #1;
    compare();
  endtask

  task automatic run_until(input int target, input int bound, input string name);
    int n = 0;
    while (m_state != target && n < bound) begin
      cycle();
      n++;
    end
    check(name, state, target);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " state"},   state,   3'd0);
    check({tag, " grst_n"},  glob_n,  1'b0);
    check({tag, " srst_n"},  soft_n,  1'b0);
    check({tag, " start_n"}, start_n, 1'b1);
    check({tag, " timeout"}, tout,    1'b0);
    check({tag, " btn_db"},  btn_db,  1'b1);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    clear_stats();
    rst_n = 1'b1;
    compare();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int hold, rst_hold;
    model_reset();
    clear_stats();
    repeat (3) cycle();
    check_reset_values("por");

    // Power-up with everything healthy runs straight through to RUN.
    lock = 1'b1; init_done = 1'b1; cal_ok = 1'b1;
    clear_stats();
    rst_n = 1'b1;
    compare();
    repeat (30) cycle();
    check("pwrup grst_n low cycles", s_glob_low, 8);
    check("pwrup srst_n low cycles", s_soft_low, 12);
    check("pwrup start_n pulses", s_start, 1);
    check("pwrup final state", state, ST_RUN);

    // PLL never locks: timeout in WAIT_LOCK.
    lock = 1'b0;
    pulse_reset();
    run_until(ST_FAULT, 200, "lock timeout reaches FAULT");
    check("wait_lock dwell within 60..68", (s_wait_lock >= 60 && s_wait_lock <= 68), 1'b1);
    check("lock timeout flag", tout, 1'b1);

    // Two ticks of low button must not change the debounced level.
    clear_stats();
    button = 1'b0;
    repeat (TICK_DIV * 2) cycle();
    button = 1'b1;
    repeat (20) cycle();
    check("short press btn_db low cycles", s_btn_low, 0);
    check("short press stays FAULT", state, ST_FAULT);

    // Long press restarts the whole sequence and clears the timeout flag.
    lock = 1'b1;
    clear_stats();
    button = 1'b0;
    run_until(ST_GRST, 40, "long press enters GRST");
    check("press clears timeout", tout, 1'b0);
    check("press btn_db low", btn_db, 1'b0);
    repeat (4) cycle();
    button = 1'b1;
    repeat (40) cycle();
    check("repeat grst_n low cycles", s_glob_low, 8);
    check("repeat srst_n low cycles", s_soft_low, 12);
    check("repeat start_n pulses", s_start, 1);
    check("repeat final state", state, ST_RUN);

    // Lock loss in RUN faults on the next cycle, without the timeout flag.
    lock = 1'b0;
    cycle();
    check("lock drop -> FAULT", state, ST_FAULT);
    check("lock drop timeout flag", tout, 1'b0);

    // Fail and success together in WAIT_CAL: fail wins, no start pulse.
    lock = 1'b1; init_done = 1'b0; cal_ok = 1'b0;
    pulse_reset();
    run_until(ST_WAIT_CAL, 50, "reach WAIT_CAL");
    cal_fail = 1'b1; cal_ok = 1'b1; init_done = 1'b1;
    cycle();
    check("fail+success -> FAULT", state, ST_FAULT);
    check("fail+success timeout flag", tout, 1'b0);
    repeat (5) cycle();
    check("fail+success start pulses", s_start, 0);
    cal_fail = 1'b0;

    // Reset asserted mid SRST takes effect without waiting for a clock.
    pulse_reset();
    run_until(ST_SRST, 50, "reach SRST");
    clear_stats();
    rst_n = 1'b0;
    #1;
    check_reset_values("async");
    model_reset();
    repeat (3) cycle();
    check("abort start pulses", s_start, 0);
    rst_n = 1'b1;

    // Randomized traffic on every input, including occasional resets.
    hold = 0;
    rst_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      cycle();
      if (hold == 0) begin
        button = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 24);
      end
      hold--;
      if ($urandom_range(0, 99) < 3) lock = ~lock;
      init_done = ($urandom_range(0, 99) < 60);
      cal_ok    = ($urandom_range(0, 99) < 40);
      cal_fail  = ($urandom_range(0, 99) < 2);
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst_n = 1'b1;
      end else if ($urandom_range(0, 999) < 3) begin
        rst_n = 1'b0;
        rst_hold = $urandom_range(1, 3);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
